// File: rtl/bcd_scan_controller.sv
// Scans a packed BCD word one digit at a time through a BCD-to-decimal
// decoder, holding each digit for DWELL cycles with a one-hot digit select.
module bcd_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Load,
  input  logic                    ContMode,
  input  logic [4*NUM_DIGITS-1:0] BCDWord,
  output logic                    Busy,
  output logic [NUM_DIGITS-1:0]   DigitSel,
  output logic [9:0]              DECOut,
  output logic                    Done,
  output logic                    ErrFlag
);

  localparam int CW = $clog2(DWELL + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  r_state, w_nstate;
  logic [4*NUM_DIGITS-1:0] r_shadow, w_nword;
  logic [4*NUM_DIGITS-1:0] r_pend, w_npend;
  logic                    r_pend_v, w_npend_v;
  logic [IW-1:0]           r_idx, w_nidx;
  logic [CW-1:0]           r_cnt, w_ncnt;
  logic                    w_start;
  logic                    w_scan;
  logic [3:0]              w_nd;
  logic [NUM_DIGITS-1:0]   w_nsel;
  logic [9:0]              w_ndec;
  logic                    w_ndone;
  logic                    w_nerr;

  always_comb begin
    w_nstate  = r_state;
    w_nword   = r_shadow;
    w_npend   = r_pend;
    w_npend_v = r_pend_v;
    w_nidx    = r_idx;
    w_ncnt    = r_cnt;
    w_start   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Load) begin
          w_nstate = SCAN;
          w_nword  = BCDWord;
          w_nidx   = '0;
          w_ncnt   = '0;
          w_start  = 1'b1;
        end
      end
      SCAN: begin
        if (r_cnt != LAST_CNT) begin
          w_ncnt = r_cnt + 1'b1;
        end else if (r_idx != LAST_IDX) begin
          w_nidx = r_idx + 1'b1;
          w_ncnt = '0;
        end else if (Load || r_pend_v || ContMode) begin
          // a Load on the Done cycle is the newest request
          w_start = 1'b1;
          w_nidx  = '0;
          w_ncnt  = '0;
          w_nword = Load ? BCDWord : (r_pend_v ? r_pend : r_shadow);
        end else begin
          w_nstate = IDLE;
        end
        if (Load && !w_start) begin
          w_npend   = BCDWord;
          w_npend_v = 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
    if (w_start) w_npend_v = 1'b0;

    w_scan = (w_nstate == SCAN);
    w_nd   = '0;
    w_nsel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(w_nidx)) begin
        w_nd      = w_nword[4*k +: 4];
        w_nsel[k] = w_scan;
      end
    end
    w_ndec = '0;
    if (w_scan) w_ndec = (w_nd > 4'd9) ? '1 : (10'd1 << w_nd);
    w_ndone = w_scan && (w_nidx == LAST_IDX) && (w_ncnt == LAST_CNT);
    w_nerr  = (w_start ? 1'b0 : ErrFlag) | (w_scan && (w_nd > 4'd9));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      Busy     <= 1'b0;
      DigitSel <= '0;
      DECOut   <= '0;
      Done     <= 1'b0;
      ErrFlag  <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_shadow <= w_nword;
      r_pend   <= w_npend;
      r_pend_v <= w_npend_v;
      r_idx    <= w_nidx;
      r_cnt    <= w_ncnt;
      Busy     <= w_scan;
      DigitSel <= w_nsel;
      DECOut   <= w_ndec;
      Done     <= w_ndone;
      ErrFlag  <= w_nerr;
    end
  end

endmodule
